// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory-port session sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, RD_ADDR, RD_DATA, RD_HOLD, DONE, ERROR
  } seq_state_e;

  localparam logic [31:0] WORD_STRIDE         = 32'd4;
  localparam logic [31:0] LOAD_BASE_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] RESULT_BASE_DEFAULT = 32'h0000_0100;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * WORD_STRIDE;
  endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Host link, CPU control and shared data-memory port of the session sequencer.
// master = sequencer side, slave = host / CPU-top side.
interface mem_port_sequencer_if;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic [31:0] ReadData;
  logic        cpu_done;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        busy;
  logic        seq_done;
  logic        error;

  modport master (
    input  start, load_valid, load_data, load_last, ReadData, cpu_done, rd_ready,
    output load_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           rd_valid, rd_data, busy, seq_done, error
  );

  modport slave (
    output start, load_valid, load_data, load_last, ReadData, cpu_done, rd_ready,
    input  load_ready, cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr,
           rd_valid, rd_data, busy, seq_done, error
  );
endinterface

// File: rtl/seq_watchdog.sv
// RUN-phase cycle counter; expired asserts in the LIMIT-th enabled cycle after clear.
// Only instantiated when SEQ_WATCHDOG_EN is defined.
module seq_watchdog #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mem_port_sequencer.sv
// Session sequencer: loads a data image, runs the CPU, then streams results back.
// Optional RUN-phase watchdog is compiled in with SEQ_WATCHDOG_EN.
module mem_port_sequencer
  import mem_seq_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE      = LOAD_BASE_DEFAULT,
  parameter int          LOAD_WORDS     = 64,
  parameter logic [31:0] RESULT_BASE    = RESULT_BASE_DEFAULT,
  parameter int          RESULT_WORDS   = 4,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input logic                  clk,
  input logic                  reset,
  mem_port_sequencer_if.master bus
);
  // state   | meaning
  // IDLE    | CPU held in reset, waiting for start
  // LOAD    | accept a beat, then write it on the next cycle
  // RUN     | CPU released, waiting for cpu_done
  // RD_ADDR | CPU in reset, result address presented
  // RD_DATA | capture ReadData after one settle cycle
  // RD_HOLD | result word offered until rd_ready
  // DONE    | one-cycle seq_done pulse
  // ERROR   | watchdog expired, waiting for start

  localparam int MAX_WORDS = (LOAD_WORDS > RESULT_WORDS) ? LOAD_WORDS : RESULT_WORDS;
  localparam int IDX_W     = $clog2(MAX_WORDS) + 1;

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic             exit_q, exit_d, first_q, first_d;
  logic             wr_q, wr_d, ready_q, ready_d;
  logic [31:0]      wdata_q, wdata_d, adr_q, adr_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             done_q, done_d, err_q, err_d;
  logic             cpu_reset_q, busy_q;
  logic             wd_expired;

  assign idx_inc = idx_q + IDX_W'(1);

`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != RUN),
    .enable  (state_q == RUN),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    exit_d     = exit_q;
    first_d    = 1'b0;
    wr_d       = 1'b0;
    ready_d    = 1'b0;
    wdata_d    = wdata_q;
    adr_d      = adr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE, ERROR: begin
        if (bus.start) begin
          state_d = LOAD;
          idx_d   = '0;
          exit_d  = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (wr_q) begin
          if (exit_q) begin
            state_d = RUN;
            first_d = 1'b1;
          end else begin
            ready_d = (idx_q < IDX_W'(LOAD_WORDS));
          end
        end else if (ready_q && bus.load_valid) begin
          wr_d    = 1'b1;
          wdata_d = bus.load_data;
          adr_d   = word_addr(LOAD_BASE, 32'(idx_q));
          idx_d   = idx_inc;
          exit_d  = bus.load_last || (idx_inc == IDX_W'(LOAD_WORDS));
        end else begin
          ready_d = ready_q;
        end
      end
      RUN: begin
        // first_q masks a cpu_done left over from the previous program
        if (!first_q && bus.cpu_done) begin
          state_d = RD_ADDR;
          idx_d   = '0;
          adr_d   = word_addr(RESULT_BASE, 32'd0);
        end else if (wd_expired) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rd_data_d  = bus.ReadData;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (idx_q == IDX_W'(RESULT_WORDS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_inc;
            adr_d   = word_addr(RESULT_BASE, 32'(idx_inc));
            state_d = RD_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      exit_q      <= 1'b0;
      first_q     <= 1'b0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b0;
      wdata_q     <= '0;
      adr_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exit_q      <= exit_d;
      first_q     <= first_d;
      wr_q        <= wr_d;
      ready_q     <= ready_d;
      wdata_q     <= wdata_d;
      adr_q       <= adr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_reset_q <= (state_d != RUN);
      busy_q      <= (state_d != IDLE) && (state_d != ERROR);
    end
  end

  assign bus.load_ready    = ready_q;
  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.Ext_MemWrite  = wr_q;
  assign bus.Ext_WriteData = wdata_q;
  assign bus.Ext_DataAdr   = adr_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.busy          = busy_q;
  assign bus.seq_done      = done_q;
  assign bus.error         = err_q;
endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Session controller for the single-cycle RISC-V CPU top and its shared data-memory port. It holds the CPU in reset while streaming a host-supplied data image into data memory through the external write port. It then releases the CPU and waits for `cpu_done`. Finally it re-asserts CPU reset and streams a result region back to the host through the same external address port. It sits between a host-side link (UART/loader) and the CPU top's `Ext_*` / `reset` inputs.

## Interface
- `LOAD_BASE`, 32'h0000_0000, byte address of the first loaded word
- `LOAD_WORDS`, 64, maximum words accepted per load phase (≥1)
- `RESULT_BASE`, 32'h0000_0100, byte address of the first result word
- `RESULT_WORDS`, 4, words read back per session (≥1)
- `TIMEOUT_CYCLES`, 100000, RUN-phase watchdog limit (used only with the watchdog compiled in)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: level; sampled only in IDLE and ERROR
- `load_valid` in 1, `load_data` in 32, `load_last` in 1, `load_ready` out 1: load stream
- `cpu_reset` out 1: drives the CPU top `reset`; also selects the external data-memory port
- `Ext_MemWrite` out 1, `Ext_WriteData` out 32, `Ext_DataAdr` out 32: external memory port
- `ReadData` in 32: data-memory read data from the CPU top
- `cpu_done` in 1: completion flag from data memory
- `rd_valid` out 1, `rd_data` out 32, `rd_ready` in 1: result stream
- `busy` out 1, `seq_done` out 1 (one-cycle pulse), `error` out 1 (sticky)

## Operation
- States: IDLE, LOAD, RUN, RD_ADDR, RD_DATA, RD_HOLD, DONE, ERROR.
- IDLE: `cpu_reset`=1, `busy`=0. `start`=1 → LOAD with word index cleared and `error` cleared.
- LOAD:
  - `load_ready`=1 while index < `LOAD_WORDS`. A beat is accepted when `load_valid && load_ready`.
  - On the next cycle `Ext_MemWrite`=1 for exactly one cycle, with `Ext_DataAdr` = `LOAD_BASE` + 4·index and `Ext_WriteData` = the beat.
  - Exit to RUN after the write of a beat carrying `load_last`, or after the write of beat `LOAD_WORDS`. `load_ready` is 0 from the accepting cycle onward.
  - Beats beyond the limit are never accepted.
- RUN:
  - `cpu_reset`=0 and `Ext_MemWrite`=0.
  - `cpu_done` is ignored in the first RUN cycle, so a stale flag is not seen. From the second cycle, `cpu_done`=1 → RD_ADDR with index cleared.
- RD_ADDR:
  - `cpu_reset`=1 and `Ext_DataAdr` = `RESULT_BASE` + 4·index.
  - Next state is RD_DATA, which captures `ReadData` into `rd_data` and moves to RD_HOLD. This gives one full cycle of address settle, so the block works with combinational or 1-cycle-latency reads.
- RD_HOLD:
  - `rd_valid`=1, with `rd_data` stable until `rd_ready`.
  - On handshake: if index = `RESULT_WORDS`−1 → DONE; otherwise increment index → RD_ADDR.
- DONE: `seq_done`=1 for one cycle → IDLE.
- Address arithmetic is 32-bit modulo 2^32. The index counter is `$clog2(max(LOAD_WORDS,RESULT_WORDS))+1` bits.
- `start` outside IDLE/ERROR is ignored. `busy`=1 in every state except IDLE and ERROR.

## Timing
- Reset values:
  - state IDLE
  - `cpu_reset`=1
  - `Ext_MemWrite`=0, `Ext_WriteData`=0, `Ext_DataAdr`=0
  - `load_ready`=0, `rd_valid`=0, `rd_data`=0
  - `busy`=0, `seq_done`=0, `error`=0
- Reset mid-session (any state): all of the above take effect on the next edge. An in-flight write is dropped, and `cpu_reset` rises the same edge.
- Load throughput: one beat per 2 cycles (accept, write). `load_ready` drops during the write cycle.
- Readback: 3 cycles minimum per word (RD_ADDR, RD_DATA, RD_HOLD with `rd_ready`=1).
- `cpu_reset` deasserts on the edge entering RUN. It reasserts on the edge leaving RUN.
- All outputs are registered.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - A RUN-cycle counter starts at 0 on RUN entry.
  - If it reaches `TIMEOUT_CYCLES` before `cpu_done`, the block goes to ERROR with `error`=1 and `cpu_reset`=1.
  - ERROR → LOAD on `start` (clears `error`).
- Not defined: RUN waits indefinitely, `error` is tied to 0, and ERROR is unreachable.

## Structure
- Package `mem_seq_pkg`: state enum, `WORD_STRIDE`=4, the default base addresses.
- One sub-module, `seq_watchdog` (clear / enable / expired), instantiated only under `SEQ_WATCHDOG_EN`.

## Test plan
- Reset, then `start`. Load 3 beats (0x11, 0x22, 0x33; `load_last` on the third) → writes at 0x0, 0x4, 0x8, one `Ext_MemWrite` pulse each, then `cpu_reset` falls.
- Stream 70 beats with `LOAD_WORDS`=64 and no `load_last` → exactly 64 writes (last at 0xFC), `load_ready` stays 0 afterwards, RUN entered.
- `cpu_done` already high on RUN entry → it is ignored for one cycle and RD_ADDR is entered on the second cycle. `rd_data` returns the 4 words at 0x100–0x10C in order, `rd_ready` is toggled randomly, data is held stable, and `seq_done` pulses once.
- `reset` asserted during LOAD after 2 beats → the next cycle shows IDLE values, no further writes, `cpu_reset`=1.
- With `SEQ_WATCHDOG_EN` and `TIMEOUT_CYCLES`=50, `cpu_done` never set → `error`=1 after 50 RUN cycles and `cpu_reset`=1. `start` then restarts LOAD with `error`=0.
